// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer and the on-screen text generator:
// FSM state encoding, countdown pause codes and the per-player score width.
package pong_pkg;

    localparam int SCORE_W = 3;

    typedef enum logic [2:0] {
        WAIT = 3'd0,
        CD3  = 3'd1,
        CD2  = 3'd2,
        CD1  = 3'd3,
        PLAY = 3'd4,
        OVER = 3'd5
    } state_t;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    // Countdown digit shown by the overlay for a given match state (P0 = blank).
    function automatic logic [1:0] pause_for(input state_t st);
        case (st)
            WAIT, CD3: pause_for = P3;
            CD2:       pause_for = P2;
            CD1:       pause_for = P1;
            default:   pause_for = P0;
        endcase
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Match-controller bus: event inputs from the game datapath and the
// score/countdown/ball-control outputs consumed by the overlay and ball logic.
interface pong_match_ctrl_if;

    logic                          refresh_tick;
    logic                          btn_start;
    logic                          miss_left;
    logic                          miss_right;
    logic [2*pong_pkg::SCORE_W-1:0] score;
    logic [1:0]                    pause;
    logic                          ball_run;
    logic                          ball_reset;
    logic                          game_over;

    modport master (
        output refresh_tick, btn_start, miss_left, miss_right,
        input  score, pause, ball_run, ball_reset, game_over
    );

    modport slave (
        input  refresh_tick, btn_start, miss_left, miss_right,
        output score, pause, ball_run, ball_reset, game_over
    );

endinterface

// File: rtl/pong_frame_timer.sv
// Counts refresh ticks while enabled; done strobes on the tick that completes
// FRAMES_PER_DIGIT frames, and the counter then restarts from zero.
module pong_frame_timer #(
    parameter int FRAMES_PER_DIGIT = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic refresh_tick,
    output logic done
);

    localparam logic [7:0] LAST = 8'(FRAMES_PER_DIGIT - 1);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    assign done = enable && refresh_tick && (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (clear || done)
            count_next = 8'd0;
        else if (enable && refresh_tick)
            count_next = count_reg + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_reg <= 8'd0;
        else
            count_reg <= count_next;
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: owns the scores and the 3-2-1 serve countdown.
// Define PONG_CD_SKIP_EN to let btn_start skip the countdown straight into play.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int FRAMES_PER_DIGIT = 60,
    parameter int WIN_SCORE        = 7
) (
    input  logic              clk,
    input  logic              reset,
    pong_match_ctrl_if.slave  bus
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_t             state_reg, state_next;
    logic [SCORE_W-1:0] left_reg, left_next;
    logic [SCORE_W-1:0] right_reg, right_next;
    logic [1:0]         pause_reg, pause_next;
    logic               ball_run_reg, ball_run_next;
    logic               ball_reset_reg, ball_reset_next;
    logic               game_over_reg, game_over_next;
    logic               timer_clear;
    logic               cd_active;
    logic               cd_done;

    assign cd_active = (state_reg == CD3) || (state_reg == CD2) || (state_reg == CD1);

    pong_frame_timer #(
        .FRAMES_PER_DIGIT(FRAMES_PER_DIGIT)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .clear        (timer_clear),
        .enable       (cd_active),
        .refresh_tick (bus.refresh_tick),
        .done         (cd_done)
    );

    always_comb begin
        state_next      = state_reg;
        left_next       = left_reg;
        right_next      = right_reg;
        ball_reset_next = 1'b0;
        timer_clear     = 1'b0;

        case (state_reg)
            WAIT: begin
                if (bus.btn_start) begin
                    state_next      = CD3;
                    timer_clear     = 1'b1;
                    ball_reset_next = 1'b1;
                end
            end
            CD3, CD2, CD1: begin
`ifdef PONG_CD_SKIP_EN
                if (bus.btn_start) begin
                    state_next  = PLAY;
                    timer_clear = 1'b1;
                end else
`endif
                if (cd_done) begin
                    case (state_reg)
                        CD3:     state_next = CD2;
                        CD2:     state_next = CD1;
                        default: state_next = PLAY;
                    endcase
                end
            end
            PLAY: begin
                // A double miss still ends the point but awards nobody.
                if (bus.miss_left || bus.miss_right) begin
                    left_next  = left_reg + SCORE_W'(bus.miss_right && !bus.miss_left);
                    right_next = right_reg + SCORE_W'(bus.miss_left && !bus.miss_right);
                    if ((left_next == WIN) || (right_next == WIN)) begin
                        state_next = OVER;
                    end else begin
                        state_next      = CD3;
                        timer_clear     = 1'b1;
                        ball_reset_next = 1'b1;
                    end
                end
            end
            OVER: begin
                if (bus.btn_start) begin
                    left_next       = '0;
                    right_next      = '0;
                    state_next      = CD3;
                    timer_clear     = 1'b1;
                    ball_reset_next = 1'b1;
                end
            end
            default: state_next = WAIT;
        endcase

        // Outputs are decoded from the upcoming state so they register alongside it.
        pause_next     = pause_for(state_next);
        ball_run_next  = (state_next == PLAY);
        game_over_next = (state_next == OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= WAIT;
            left_reg       <= '0;
            right_reg      <= '0;
            pause_reg      <= P3;
            ball_run_reg   <= 1'b0;
            ball_reset_reg <= 1'b0;
            game_over_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            left_reg       <= left_next;
            right_reg      <= right_next;
            pause_reg      <= pause_next;
            ball_run_reg   <= ball_run_next;
            ball_reset_reg <= ball_reset_next;
            game_over_reg  <= game_over_next;
        end
    end

    assign bus.score      = {left_reg, right_reg};
    assign bus.pause      = pause_reg;
    assign bus.ball_run   = ball_run_reg;
    assign bus.ball_reset = ball_reset_reg;
    assign bus.game_over  = game_over_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed scenarios plus random
// traffic compared cycle by cycle against a match-level reference model.
module tb_pong_match_ctrl;

    localparam int FPD = 2;
    localparam int WIN = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pong_match_ctrl_if bus ();

    pong_match_ctrl #(
        .FRAMES_PER_DIGIT (FPD),
        .WIN_SCORE        (WIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: match phase, ticks counted since the countdown began, scores.
    typedef enum int {M_IDLE, M_COUNT, M_RALLY, M_DONE} mode_t;
    mode_t m_mode;
    int    m_ticks;
    int    m_left, m_right;
    bit    m_pulse;

    task automatic model_reset();
        m_mode = M_IDLE; m_ticks = 0; m_left = 0; m_right = 0; m_pulse = 0;
    endtask

    task automatic start_countdown();
        m_mode = M_COUNT; m_ticks = 0; m_pulse = 1;
    endtask

    task automatic model_step(input bit t, input bit s, input bit ml, input bit mr);
        m_pulse = 0;
        case (m_mode)
            M_IDLE:  if (s) start_countdown();
            M_COUNT: begin
`ifdef PONG_CD_SKIP_EN
                if (s) m_mode = M_RALLY;
                else
`endif
                if (t) begin
                    m_ticks++;
                    if (m_ticks == 3 * FPD) m_mode = M_RALLY;
                end
            end
            M_RALLY: if (ml || mr) begin
                if (ml && !mr) m_right++;
                if (mr && !ml) m_left++;
                if (m_left == WIN || m_right == WIN) m_mode = M_DONE;
                else start_countdown();
            end
            M_DONE: if (s) begin
                m_left = 0; m_right = 0;
                start_countdown();
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_pause;
        logic [7:0] exp_score;
        exp_pause = (m_mode == M_IDLE)  ? 8'd3 :
                    (m_mode == M_COUNT) ? 8'(3 - m_ticks / FPD) : 8'd0;
        exp_score = {2'b00, 3'(m_left), 3'(m_right)};
        check("score",      {2'b00, bus.score},      exp_score);
        check("pause",      {6'd0, bus.pause},       exp_pause);
        check("ball_run",   {7'd0, bus.ball_run},    {7'd0, m_mode == M_RALLY});
        check("ball_reset", {7'd0, bus.ball_reset},  {7'd0, m_pulse});
        check("game_over",  {7'd0, bus.game_over},   {7'd0, m_mode == M_DONE});
        $display("[TB] t=%0t in=%b%b%b%b score=%b pause=%0d run=%b brst=%b over=%b",
                 $time, bus.refresh_tick, bus.btn_start, bus.miss_left, bus.miss_right,
                 bus.score, bus.pause, bus.ball_run, bus.ball_reset, bus.game_over);
    endtask

    task automatic cycle(input bit t, input bit s, input bit ml, input bit mr);
        @(negedge clk);
        bus.refresh_tick = t;
        bus.btn_start    = s;
        bus.miss_left    = ml;
        bus.miss_right   = mr;
        @(posedge clk);
        model_step(t, s, ml, mr);
        #1 check_all();
    endtask

    task automatic run_countdown();
        for (int i = 0; i < 3 * FPD; i++) begin
            cycle(1, 0, 0, 0);
            cycle(0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.refresh_tick = 0; bus.btn_start = 0; bus.miss_left = 0; bus.miss_right = 0;
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.refresh_tick = 0; bus.btn_start = 0; bus.miss_left = 0; bus.miss_right = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) reset = 1'b0;
        cycle(0, 0, 1, 1);

        // Start with a coincident tick that must not count, then the full countdown.
        cycle(1, 1, 0, 0);
        run_countdown();
        cycle(0, 0, 0, 0);

        // Right miss scores for left; then a double miss awards nobody.
        cycle(0, 0, 0, 1);
        run_countdown();
        cycle(0, 0, 1, 1);
        run_countdown();

        // Build a 3-1 score, then reset asynchronously during CD2.
        cycle(0, 0, 0, 1); run_countdown();
        cycle(0, 0, 0, 1); run_countdown();
        cycle(0, 0, 1, 0); cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
        do_reset();
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);

        // btn_start during CD3: skip to play when enabled, ignored otherwise.
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        do_reset();

        // Play the left player out to WIN points, then restart from game over.
        cycle(0, 1, 0, 0);
        run_countdown();
        for (int p = 0; p < WIN; p++) begin
            cycle(0, 0, 1, 0);
            if (p < WIN - 1) run_countdown();
        end
        cycle(1, 0, 1, 1);
        cycle(0, 1, 0, 0);
        run_countdown();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) < 4, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the VGA Pong game. It owns the score registers and the serve countdown. It drives the packed `score` and `pause` buses consumed by the on-screen text generator, and enables or recentres the ball logic. It sits between the ball/paddle datapath, which reports misses, and the text overlay, which displays scores and the countdown digit.

## Interface
- `FRAMES_PER_DIGIT`, default 60: refresh ticks each countdown digit stays on screen; legal range 1..255.
- `WIN_SCORE`, default 7: points that end the match; legal range 1..7.
- `clk` input, 1 bit: system pixel clock.
- `reset` input, 1 bit: asynchronous, active-high; clock `clk`.
- `refresh_tick` input, 1 bit: one-cycle pulse at start of each video frame.
- `btn_start` input, 1 bit: debounced one-cycle start pulse.
- `miss_left` input, 1 bit: one-cycle pulse; ball passed left paddle.
- `miss_right` input, 1 bit: one-cycle pulse; ball passed right paddle.
- `score` output, 6 bits: `[5:3]` left score, `[2:0]` right score, binary.
- `pause` output, 2 bits: countdown digit; 3/2/1 show the digit, 0 shows blank.
- `ball_run` output, 1 bit: ball motion enable.
- `ball_reset` output, 1 bit: one-cycle pulse that recentres the ball.
- `game_over` output, 1 bit: high while the match is finished.

## Operation
- The FSM has six states: WAIT, CD3, CD2, CD1, PLAY, OVER. All outputs are registered and decoded from the state and score registers (Moore).
- Reset values: state WAIT, `score`=0, `pause`=3, `ball_run`=0, `ball_reset`=0, `game_over`=0, frame counter 0.
- WAIT:
  - `pause`=3.
  - `btn_start` moves to CD3, clears the frame counter and pulses `ball_reset`.
- CD3, CD2 and CD1:
  - `pause` = 3, 2 and 1 respectively.
  - The frame counter increments on each `refresh_tick`.
  - A tick arriving while the counter equals `FRAMES_PER_DIGIT-1` clears the counter and advances CD3→CD2→CD1→PLAY.
- PLAY:
  - `pause`=0 and `ball_run`=1.
  - `miss_left` alone increments the right score. `miss_right` alone increments the left score.
  - Both misses in the same cycle change neither score, but are still treated as a point end.
  - After any point end: if the new score equals `WIN_SCORE`, go to OVER. Otherwise go to CD3, clear the frame counter and pulse `ball_reset`.
- OVER:
  - `pause`=0, `ball_run`=0, `game_over`=1, scores held.
  - `btn_start` clears both scores and `game_over`, goes to CD3 and pulses `ball_reset`.
- Ignored inputs: misses outside PLAY; `btn_start` in CD3/CD2/CD1/PLAY, except as described under Configuration.
- Score arithmetic: 3-bit unsigned. Scores never exceed `WIN_SCORE`, so there is no wrap.
- Reset asserted mid-match: immediate return to reset values, including scores.

## Timing
- An input sampled at rising edge N produces its state and output change visible after edge N, i.e. 1-cycle latency.
- `ball_reset` is high for exactly one cycle: the cycle following the triggering edge.
- `ball_run` deasserts in the same cycle that `ball_reset` asserts on a point end.
- Countdown duration is exactly 3×`FRAMES_PER_DIGIT` refresh ticks.
- The first tick counted is the first `refresh_tick` strictly after entry to CD3.
- A `refresh_tick` coincident with the entry edge is not counted.

## Configuration
- Macro `PONG_CD_SKIP_EN`.
- Defined: `btn_start` during CD3, CD2 or CD1 jumps straight to PLAY and clears the frame counter. No `ball_reset` pulse is issued.
- Undefined: `btn_start` is ignored during the countdown. No skip logic is synthesized.

## Structure
- Shared package `pong_pkg` holds:
  - state encoding constants (WAIT..OVER);
  - pause codes P0=0, P1=1, P2=2, P3=3;
  - the score width of 3, shared with the text generator.
- Sub-module `pong_frame_timer`:
  - counts `refresh_tick` up to `FRAMES_PER_DIGIT-1`;
  - has a synchronous clear input and outputs a `done` strobe.
- All other logic (FSM, score registers, output registers) lives in `pong_match_ctrl`.

## Test plan
- Reset, then `btn_start`, with `FRAMES_PER_DIGIT`=2 → `pause` reads 3,3,2,1, then 0 after 6 ticks. `ball_run`=1 after the 6th tick. `ball_reset` pulses once.
- In PLAY, pulse `miss_right` → `score`=6'b001_000, one `ball_reset` pulse, state CD3, `pause`=3.
- In PLAY, pulse `miss_left` and `miss_right` in the same cycle → `score` unchanged, CD3 entered, one `ball_reset` pulse.
- `WIN_SCORE`=2: two `miss_left` points → `score`=6'b000_010, `game_over`=1, `ball_run`=0. Then `btn_start` → `score`=0 and `pause`=3.
- Assert `reset` during CD2 with `score`=6'b011_001 → outputs immediately become 0 / `pause`=3 / WAIT. Misses pulsed in WAIT leave `score`=0.
- With `PONG_CD_SKIP_EN` defined, `btn_start` in CD3 → PLAY next cycle, `pause`=0, no `ball_reset`. Without the macro → stays in CD3.
